// File: rtl/dlatch_write_seq_if.sv
// Request/latch-bus bundle between the write requester and the latch write
// sequencer. The master drives write requests; the slave is the sequencer.
interface dlatch_write_seq_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
);
  logic             req_valid;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_data;
  logic             req_ready;
  logic [WIDTH-1:0] d_out;
  logic [DEPTH-1:0] en_out;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, d_out, en_out, done, err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, d_out, en_out, done, err, busy
  );
endinterface

// File: rtl/dlatch_write_seq.sv
// Write sequencer for a bank of level-sensitive D-latch words. Captures one
// request at a time, puts the data on the shared D bus, then raises exactly
// one latch enable with programmable setup, pulse and hold margins.
module dlatch_write_seq #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = 2,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 1,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  dlatch_write_seq_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  // One extra bit so DEPTH = 2^AW is still representable for the range check.
  localparam logic [AW:0]      DEPTH_LIM = DEPTH[AW:0];
  localparam logic [DEPTH-1:0] EN_ONE    = DEPTH'(1);

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] d_q;
  logic [DEPTH-1:0] en_q;
  logic             ready_q;
  logic             done_q;
  logic             err_q;
  logic             accept;
  logic             addr_ok;

  // ready_q is only ever high in IDLE, so accept implies the FSM is idle.
  assign accept  = bus.req_valid && ready_q;
  assign addr_ok = {1'b0, bus.req_addr} < DEPTH_LIM;

  // Sequencer FSM: phase timing, registered enables, D bus and status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      en_q    <= '0;
      d_q     <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            if (addr_ok) begin
              state   <= SETUP;
              cnt     <= SETUP_LD;
              d_q     <= bus.req_data;
              ready_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            state <= PULSE;
            cnt   <= PULSE_LD;
            en_q  <= EN_ONE << addr_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PULSE: begin
          if (cnt == 4'd0) begin
            state <= HOLD;
            cnt   <= HOLD_LD;
            en_q  <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            state   <= IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          en_q  <= '0;
        end
      endcase
    end
  end

  // Target address capture; only consumed while a write is in flight.
  always_ff @(posedge clk) begin
    if (accept && addr_ok) begin
      addr_q <= bus.req_addr;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.d_out     = d_q;
  assign bus.en_out    = en_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_dlatch_write_seq.sv
// Bench for dlatch_write_seq: two instances (S/P/H = 2/1/1 and 3/4/2) checked
// every cycle against a timeline model counting cycles since each accept.
module tb_dlatch_write_seq;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  dlatch_write_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) ifa ();
  dlatch_write_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) ifb ();

  dlatch_write_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
                     .SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  dlatch_write_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW),
                     .SETUP_CYC(3), .PULSE_CYC(4), .HOLD_CYC(2))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int ms[2] = '{2, 3};
  int mp[2] = '{1, 4};
  int mh[2] = '{1, 2};

  logic             vld[2];
  logic [AW-1:0]    adr[2];
  logic [WIDTH-1:0] dat[2];

  assign ifa.req_valid = vld[0];
  assign ifa.req_addr  = adr[0];
  assign ifa.req_data  = dat[0];
  assign ifb.req_valid = vld[1];
  assign ifb.req_addr  = adr[1];
  assign ifb.req_data  = dat[1];

  logic [WIDTH-1:0] o_d[2];
  logic [DEPTH-1:0] o_en[2];
  logic             o_rdy[2], o_done[2], o_err[2], o_busy[2];

  assign o_d[0]    = ifa.d_out;
  assign o_en[0]   = ifa.en_out;
  assign o_rdy[0]  = ifa.req_ready;
  assign o_done[0] = ifa.done;
  assign o_err[0]  = ifa.err;
  assign o_busy[0] = ifa.busy;
  assign o_d[1]    = ifb.d_out;
  assign o_en[1]   = ifb.en_out;
  assign o_rdy[1]  = ifb.req_ready;
  assign o_done[1] = ifb.done;
  assign o_err[1]  = ifb.err;
  assign o_busy[1] = ifb.busy;

  // Reference: mt = cycles since the accept edge (-1 when no write in flight).
  int mt[2], ma[2], md[2];
  bit mrdy[2], mdone[2], merr[2], macc[2];
  int seen_done[2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int e;
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      macc[k] = 1'b0;
      if (!rst_n) begin
        mt[k] = -1; md[k] = 0; mrdy[k] = 1'b0; mdone[k] = 1'b0; merr[k] = 1'b0;
      end else begin
        mdone[k] = 1'b0;
        merr[k]  = 1'b0;
        if (mt[k] >= 0) begin
          mt[k]++;
          if (mt[k] == ms[k] + mp[k] + mh[k]) begin
            mt[k] = -1;
            mdone[k] = 1'b1;
          end
        end else if (mrdy[k] && vld[k]) begin
          macc[k] = 1'b1;
          if (int'(adr[k]) >= DEPTH) begin
            merr[k] = 1'b1;
          end else begin
            mt[k] = 0;
            md[k] = int'(dat[k]);
            ma[k] = int'(adr[k]);
          end
        end
        mrdy[k] = (mt[k] < 0);
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      e = (mt[k] >= ms[k] && mt[k] < ms[k] + mp[k]) ? (1 << ma[k]) : 0;
      if (o_done[k] === 1'b1) seen_done[k]++;
      chk("d_out", k, 32'(o_d[k]), 32'(md[k]));
      chk("en_out", k, 32'(o_en[k]), 32'(e));
      chk("done", k, 32'(o_done[k]), 32'(mdone[k]));
      chk("err", k, 32'(o_err[k]), 32'(merr[k]));
      chk("busy", k, 32'(o_busy[k]), (mt[k] >= 0) ? 32'd1 : 32'd0);
      chk("req_ready", k, 32'(o_rdy[k]), 32'(mrdy[k]));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int k, input int a, input int d);
    bit got;
    got = 1'b0;
    vld[k] = 1'b1;
    adr[k] = AW'(a);
    dat[k] = WIDTH'(d);
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      got = macc[k];
    end
    vld[k] = 1'b0;
    chk("accept_wait", k, 32'(got), 32'd1);
  endtask

  initial begin
    int d0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; adr[k] = '0; dat[k] = '0;
      mt[k] = -1; ma[k] = 0; md[k] = 0; seen_done[k] = 0;
      mrdy[k] = 1'b0; mdone[k] = 1'b0; merr[k] = 1'b0; macc[k] = 1'b0;
    end
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(2);

    // Single write, addr 2 data A5
    send(0, 2, 'hA5);
    run(6);

    // Back-to-back with valid held high across the done cycle
    d0 = seen_done[0];
    send(0, 1, 'h3C);
    send(0, 3, 'hF0);
    run(6);
    chk("b2b_done_pulses", 0, 32'(seen_done[0] - d0), 32'd2);

    // Out-of-range address
    send(0, 5, 'h77);
    run(2);

    // Reset while the enable is high
    d0 = seen_done[0];
    send(0, 2, 'h11);
    for (int i = 0; i < 10 && mt[0] != ms[0]; i++) step();
    chk("reached_pulse", 0, 32'(o_en[0]), 32'h4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    run(5);
    chk("reset_no_done", 0, 32'(seen_done[0] - d0), 32'd0);

    // Long margins on the second instance, with a stray request in SETUP
    d0 = seen_done[1];
    send(1, 0, 'h81);
    vld[1] = 1'b1; adr[1] = 3'd2; dat[1] = 8'h55;
    step();
    vld[1] = 1'b0;
    run(12);
    chk("busy_req_ignored", 1, 32'(seen_done[1] - d0), 32'd1);

    // Randomized traffic on both instances, requester holds until accepted
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!vld[k] || macc[k]) begin
          vld[k] = ($urandom_range(0, 2) != 0);
          adr[k] = AW'($urandom_range(0, 7));
          dat[k] = WIDTH'($urandom);
        end
      end
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dlatch_write_seq.md
# dlatch_write_seq

Write sequencer that drives the D and En inputs of a bank of level-sensitive D-latch words. It accepts one write request at a time over a valid/ready handshake. It presents the data on the shared D bus, pulses exactly one latch enable, and holds D stable around that pulse so each latch sees programmable setup and hold margins. It sits between synchronous control logic and the latch-based storage array, and is the only writer of that array.

## Interface
Parameters:
- WIDTH, 8: data width of each latch word and of the D bus.
- DEPTH, 4: number of latch words; one enable line each.
- AW, 2: address width; DEPTH ≤ 2^AW.
- SETUP_CYC, 1: cycles D is stable before the enable rises; legal range 1..15.
- PULSE_CYC, 1: cycles the enable is high; legal range 1..15.
- HOLD_CYC, 1: cycles D is stable after the enable falls; legal range 1..15.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- req_valid, input, 1: write request present.
- req_addr, input, AW: target latch word.
- req_data, input, WIDTH: value to store.
- req_ready, output, 1: sequencer can accept a request.
- d_out, output, WIDTH: shared D bus to all latch words.
- en_out, output, DEPTH: one-hot or zero latch enables.
- done, output, 1: one-cycle pulse when a write completes.
- err, output, 1: one-cycle pulse when a request is rejected because its address is out of range.
- busy, output, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- Reset values (rst_n sampled low): state=IDLE; d_out=0; en_out=0; done=0; err=0; busy=0; req_ready=0.
- Ready rule: req_ready=1 only in IDLE with reset released.
- Accept rule: a request is accepted on an edge where req_valid && req_ready. addr and data are captured into registers on that edge.
- Out-of-range request (req_addr ≥ DEPTH):
  - err=1 for the next cycle.
  - en_out stays 0 and d_out is unchanged.
  - The FSM stays in IDLE.
- IDLE → SETUP on a valid accept. d_out = captured data; en_out = 0.
- SETUP lasts SETUP_CYC cycles, then → PULSE.
- PULSE: en_out[addr]=1 and all other bits 0, for PULSE_CYC cycles, then → HOLD.
- HOLD: en_out=0 and d_out unchanged, for HOLD_CYC cycles, then → IDLE with done=1 for one cycle.
- d_out changes only on the accept edge. It retains the last written value while IDLE.
- en_out is driven directly from flops: no combinational decode and no glitches on the enables.
- Only one bit of en_out is high at any time.
- A single down-counter of 4 bits is reloaded on each state entry.
- Requests presented while busy are ignored; the requester must hold req_valid until it sees req_ready.

## Timing
- Timing is counted from accept edge T0 (cycle 0 = the cycle after T0). Let S, P, H be SETUP_CYC, PULSE_CYC, HOLD_CYC.
  - d_out = new data from cycle 0 onward.
  - en_out high in cycles S .. S+P-1.
  - HOLD covers cycles S+P .. S+P+H-1.
  - done=1 and req_ready=1 in cycle S+P+H.
- Back-to-back writes: the next accept can occur at the edge that ends cycle S+P+H. The minimum write period is S+P+H+1 cycles.
- err is high in cycle 0 after an out-of-range accept. req_ready stays 1, so the next request can be accepted at the following edge.
- Reset mid-operation: at the edge where rst_n is sampled low, en_out→0, d_out→0, and state→IDLE. The in-flight write is abandoned with no done pulse. req_ready=1 in the first cycle after rst_n is sampled high.
- done and err are never high in the same cycle.

## Test plan
- Parameters WIDTH=8, DEPTH=4, S=2, P=1, H=1. Write addr=2, data=0xA5 → d_out=0xA5 from cycle 0; en_out=4'b0100 only in cycle 2; done=1 and req_ready=1 in cycle 4.
- Same parameters, back-to-back writes (1, 0x3C) then (3, 0xF0) with req_valid held high → en_out=4'b0010 in cycle 2 and 4'b1000 in cycle 7; d_out=0xF0 from cycle 5; exactly two done pulses.
- Write with addr=5 and DEPTH=4 (AW=3) → err=1 for one cycle; en_out stays 0; d_out keeps its prior value; req_ready stays 1.
- Reset during PULSE: rst_n low for one edge → en_out=0 and d_out=0 at that edge; no done pulse; req_ready=1 one cycle after release.
- S=3, P=4, H=2, write addr=0, data=0x81 → en_out[0] high for exactly cycles 3..6; done in cycle 9; d_out constant in cycles 0..9.
- req_valid pulsed while busy (during SETUP) → request ignored; no extra en_out activity; the FSM completes the original write unchanged.
